// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the sequential ALU.
// Imported by seq_alu and seq_alu_iter.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MULHU = 4'b0101;
    localparam logic [3:0] OP_DIVU  = 4'b0110;
    localparam logic [3:0] OP_REMU  = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cntWidth(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and, when SEQ_ALU_DIV_EN
// is defined, restoring divide. Sequenced by the seq_alu FSM via start_i/step_i.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = cntWidth(WIDTH);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulStep;

    // Multiply: {hi, lo} starts as {0, multiplier}; add multiplicand into hi when lo[0] is set, then shift right.
    always_comb begin
        mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
        mulStep = {mulSum, acc_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic               isDiv_q, isDiv_d;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] divStep;

    // Divide: {rem, quotient} shifts left; a clear borrow means the trial subtraction is kept.
    always_comb begin
        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff  = trial - {1'b0, opB_q};
        if (!diff[WIDTH]) begin
            divStep = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            divStep = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        opB_d = opB_q;
`ifdef SEQ_ALU_DIV_EN
        isDiv_d = isDiv_q;
`endif
        if (start_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            opB_d = b_i;
            cnt_d = CW'(WIDTH - 1);
`ifdef SEQ_ALU_DIV_EN
            isDiv_d = div_i;
`endif
        end else if (step_i) begin
`ifdef SEQ_ALU_DIV_EN
            acc_d = isDiv_q ? divStep : mulStep;
`else
            acc_d = mulStep;
`endif
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            opB_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            isDiv_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opB_q <= opB_d;
`ifdef SEQ_ALU_DIV_EN
            isDiv_q <= isDiv_d;
`endif
        end
    end

    // Results come from the next-state value so the final step can be registered on the same edge.
    assign last_o = (cnt_q == '0);
    assign hi_o   = acc_d[2*WIDTH-1:WIDTH];
    assign lo_o   = acc_d[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes; iterative MUL/MULHU and, with
// SEQ_ALU_DIV_EN defined, DIVU/REMU. Other ops complete in one cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             isIter;
    logic             start;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] singleResult;
    logic [WIDTH-1:0] iterResult;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle results; a zero divisor is resolved here so it never iterates.
    always_comb begin
        singleResult = '0;
        isIter       = 1'b0;
        case (alu_control)
            OP_AND:   singleResult = in1 & in2;
            OP_OR:    singleResult = in1 | in2;
            OP_ADD:   singleResult = in1 + in2;
            OP_SUB:   singleResult = in1 - in2;
            OP_SLT:   singleResult = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_MUL,
            OP_MULHU: isIter = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU: begin
                if (in2 == '0) singleResult = '1;
                else           isIter = 1'b1;
            end
            OP_REMU: begin
                if (in2 == '0) singleResult = in1;
                else           isIter = 1'b1;
            end
`endif
            default:  singleResult = '0;
        endcase
    end

    always_comb begin
        iterResult = lo;
        case (op_q)
            OP_MULHU: iterResult = hi;
`ifdef SEQ_ALU_DIV_EN
            OP_REMU:  iterResult = hi;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        start    = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    op_d = alu_control;
                    if (isIter) begin
                        start   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d  = DONE;
                        result_d = singleResult;
                        zero_d   = (singleResult == '0);
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_d  = DONE;
                    result_d = iterResult;
                    zero_d   = (iterResult == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    seq_alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .step_i  (step),
`ifdef SEQ_ALU_DIV_EN
        .div_i   ((alu_control == OP_DIVU) || (alu_control == OP_REMU)),
`endif
        .a_i     (in1),
        .b_i     (in2),
        .last_o  (last),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    assign out_valid  = (state_q == DONE);
    assign alu_result = result_q;
    assign zero_flag  = zero_q;
    assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu (WIDTH=32); expectations follow
// SEQ_ALU_DIV_EN when the macro is defined for the build.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [3:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero_flag;
    logic         busy;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        int           lat;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model built from plain arithmetic operators.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] prod;
        prod     = {32'b0, a} * {32'b0, b};
        e.result = '0;
        e.lat    = 1;
        case (op)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: e.result = a + b;
            4'b0100: e.result = a - b;
            4'b1000: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: begin e.result = prod[31:0];  e.lat = W + 1; end
            4'b0101: begin e.result = prod[63:32]; e.lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
            4'b0110: begin
                if (b == 0) e.result = 32'hFFFF_FFFF;
                else begin e.result = a / b; e.lat = W + 1; end
            end
            4'b0111: begin
                if (b == 0) e.result = a;
                else begin e.result = a % b; e.lat = W + 1; end
            end
`endif
            default: e.result = '0;
        endcase
        e.zero = (e.result == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waitCycles = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = op;
        in1         = a;
        in2         = b;
        #1;
        while (!in_ready && waitCycles < 100) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        check("accept", in_ready, 1);
        sbQ.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in1         = $urandom;
        in2         = $urandom;
        alu_control = 4'($urandom_range(0, 15));
    endtask

    // Called right after the acceptance edge; measures latency and busy cycles.
    task automatic checkOutput(input string tag);
        int   lat     = 1;
        int   busyCnt = 0;
        exp_t e;
        while (!out_valid && lat < 100) begin
            if (busy && !in_ready) busyCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s_scoreboard: observed empty expected entry", tag);
        end else begin
            e = sbQ.pop_front();
            check({tag, "_result"}, alu_result, e.result);
            check({tag, "_zero"}, zero_flag, e.zero);
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_busycycles"}, busyCnt, e.lat - 1);
        end
        @(posedge clk);
        #1;
        check({tag, "_drain"}, out_valid, 0);
    endtask

    task automatic compareFront(input string tag);
        exp_t e;
        check({tag, "_valid"}, out_valid, 1);
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s_scoreboard: observed empty expected entry", tag);
        end else begin
            e = sbQ.pop_front();
            check({tag, "_result"}, alu_result, e.result);
            check({tag, "_zero"}, zero_flag, e.zero);
        end
    endtask

    logic [3:0] opList [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1111};
    logic [3:0] bbOps  [4]  = '{4'b0010, 4'b0001, 4'b0100, 4'b1000};
    exp_t       held;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in1         = '0;
        in2         = '0;
        alu_control = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_result", alu_result, 0);
        check("reset_zero", zero_flag, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", in_ready, 1);
        rst = 1'b0;

        applyStimulus(4'b0010, 32'd23, 32'd42);          checkOutput("add");
        applyStimulus(4'b0100, 32'd23, 32'd42);          checkOutput("sub");
        applyStimulus(4'b1000, 32'd42, 32'd23);          checkOutput("slt_pos");
        applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'd1);    checkOutput("slt_neg");
        applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'd2);    checkOutput("mul");
        applyStimulus(4'b0101, 32'hFFFF_FFFF, 32'd2);    checkOutput("mulhu");
        applyStimulus(4'b0110, 32'd42, 32'd5);           checkOutput("divu");
        applyStimulus(4'b0111, 32'd42, 32'd5);           checkOutput("remu");
        applyStimulus(4'b0110, 32'd42, 32'd0);           checkOutput("divu_zero");
        applyStimulus(4'b0111, 32'd42, 32'd0);           checkOutput("remu_zero");
        applyStimulus(4'b1111, 32'd7, 32'd9);            checkOutput("undef");
        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1);    checkOutput("add_wrap");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(opList[$urandom_range(0, 9)], $urandom, $urandom);
            checkOutput("random");
        end

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_ready", in_ready, 1);
                compareFront("b2b");
            end
            in_valid    = 1'b1;
            alu_control = bbOps[i];
            in1         = $urandom;
            in2         = $urandom;
            sbQ.push_back(model(bbOps[i], in1, in2));
        end
        @(negedge clk);
        compareFront("b2b_last");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_drain", out_valid, 0);

        // Backpressure with a pending request released on the same edge.
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = 4'b0010;
        in1         = 32'd100;
        in2         = 32'd200;
        held        = model(4'b0010, 32'd100, 32'd200);
        @(posedge clk);
        #1;
        out_ready   = 1'b0;
        alu_control = 4'b0100;
        in1         = 32'd9;
        in2         = 32'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_result", alu_result, held.result);
            check("bp_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        sbQ.push_back(model(4'b0100, 32'd9, 32'd3));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        compareFront("bp_next");
        @(posedge clk);
        #1;
        check("bp_drain", out_valid, 0);

        // Reset in the middle of a multiply aborts it.
        applyStimulus(4'b0011, 32'd12345, 32'd678);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.delete();
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_result", alu_result, 0);
        check("abort_ready", in_ready, 1);
        applyStimulus(4'b0010, 32'd1, 32'd1);            checkOutput("post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised successor to the single-cycle RISC-V ALU. It covers the base ALU operations plus an iterative unsigned multiply and divide unit, exposed behind a valid/ready handshake on both input and output. It sits between the decode/issue stage and writeback, and stalls issue through `in_ready` while an iterative operation is in flight.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥ 4).
- `clk`  input  1  clock, all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  operation request present.
- `in_ready`  output  1  block accepts a request this cycle.
- `in1`  input  WIDTH  operand A.
- `in2`  input  WIDTH  operand B.
- `alu_control`  input  4  operation code.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer takes the result this cycle.
- `alu_result`  output  WIDTH  result.
- `zero_flag`  output  1  `alu_result == 0`; qualified by `out_valid`.
- `busy`  output  1  an iterative operation is in progress.

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0100 SUB; 1000 SLT (signed, result 1 or 0).
  - 0011 MUL (low WIDTH bits of the unsigned product).
  - 0101 MULHU (high WIDTH bits).
  - 0110 DIVU (quotient); 0111 REMU (remainder).
  - Any other code gives result 0 with single-cycle latency.
- All arithmetic is modulo 2^WIDTH. ADD and SUB wrap silently.
- Operands and opcode are captured on acceptance (`in_valid && in_ready`). Later input changes are ignored.
- MUL/MULHU use a shift-add iteration: one bit per cycle, WIDTH iterations, 2·WIDTH-bit accumulator.
- DIVU/REMU use restoring division: one bit per cycle, WIDTH iterations.
- Divide by zero is detected at acceptance and skips iteration:
  - DIVU returns all-ones.
  - REMU returns `in1`.
- States:
  - IDLE → DONE on acceptance of a single-cycle op or a divide by zero.
  - IDLE → BUSY on acceptance of an iterative op, with the counter loaded to WIDTH−1.
  - BUSY → BUSY while counter ≠ 0, decrementing each cycle.
  - BUSY → DONE when counter = 0.
  - DONE → IDLE on `out_ready` with no new acceptance.
  - DONE → DONE or BUSY on `out_ready` with a simultaneous acceptance.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). This is a combinational path from `out_ready` and is allowed.
- `busy` = (state == BUSY).

## Timing
- Reset values: `out_valid` 0, `alu_result` 0, `zero_flag` 0, `busy` 0. State is IDLE, counter 0.
- Acceptance is at edge 0.
  - Single-cycle ops and divide by zero: `out_valid` is high after edge 1 (latency 1).
  - MUL/MULHU/DIVU/REMU: `out_valid` is high after edge WIDTH+1 (latency WIDTH+1; 33 for WIDTH=32).
- `alu_result` and `zero_flag` are registered. They stay stable while `out_valid && !out_ready`.
- Back-to-back single-cycle ops with `out_ready` held high sustain 1 op/cycle.
- `rst` asserted in any state, including mid-BUSY, aborts the operation. On the next edge the block is in IDLE with reset values, and no result is produced for the aborted request.
- `in_ready` is low throughout BUSY. A request held during BUSY is not accepted until DONE with `out_ready`, or IDLE.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIVU/REMU are implemented as specified above.
- `SEQ_ALU_DIV_EN` undefined:
  - No divider logic is built.
  - Opcodes 0110/0111 behave as undefined codes: result 0, latency 1.
  - MUL/MULHU are unaffected.

## Structure
- Package `seq_alu_pkg` holds:
  - the opcode localparams (`OP_AND` … `OP_REMU`);
  - the state enum `IDLE`/`BUSY`/`DONE`;
  - the counter width function `$clog2(WIDTH)`.
- Sub-module `seq_alu_iter`:
  - Holds the shared shift-add/restoring iteration datapath (accumulator, shifted operand, counter step).
  - Is controlled by the top-level FSM.
  - Its divider half sits under `SEQ_ALU_DIV_EN`.
- Single-cycle ops are computed combinationally in the top level and registered into `alu_result`.

## Test plan
- ADD 23, 42 accepted from reset with `out_ready` = 1 → `out_valid` after 1 edge, result 65, `zero_flag` 0; then SUB 23, 42 → 0xFFFFFFED.
- SLT 42, 23 → 0 with `zero_flag` 1. SLT 0xFFFFFFFF, 1 → 1 (signed compare).
- MUL 0xFFFFFFFF, 2 → 0xFFFFFFFE after exactly 33 edges, `busy` high edges 1–32, `in_ready` low throughout. MULHU on the same operands → 1.
- DIVU 42, 5 → 8 and REMU 42, 5 → 2, each at latency 33. DIVU 42, 0 → 0xFFFFFFFF and REMU 42, 0 → 42, each at latency 1. Without `SEQ_ALU_DIV_EN`, DIVU 42, 5 → 0 at latency 1.
- Backpressure: `out_ready` held 0 for 5 cycles after an ADD result → `alu_result`/`out_valid` stable, `in_ready` 0. Release together with a pending `in_valid` → both handshakes complete in the same cycle.
- Reset mid-MUL at edge 10 → next edge `busy` 0, `out_valid` 0, `alu_result` 0, `in_ready` 1. A following ADD 1, 1 → 2 at latency 1.
